// File: rtl/ball_game_engine_if.sv
// ---------------------------------------------------------------------------
// ball_game_engine_if
//   Groups the frame-rate control inputs and the game-state outputs of the
//   ball game engine into one bundle.
//
//   Signals
//     frameTick        1   one-cycle pulse per video frame
//     startButton      1   level, only looked at on frameTick cycles
//     playerPaddleY    16  top y of the left (player) paddle
//     computerPaddleY  16  top y of the right (computer) paddle
//     gameState        8   0=attract 1=serve 2=play 3=game over
//     ballX            16  ball left x
//     ballY            16  ball top y
//     playerScore      8   player points
//     computerScore    8   computer points
//     scoreEvent       1   one-cycle pulse when a score increments
//
//   Modports
//     master  drives the frame/paddle inputs, observes the game outputs
//     slave   the engine side
// ---------------------------------------------------------------------------
interface ball_game_engine_if;
  logic        frameTick;
  logic        startButton;
  logic [15:0] playerPaddleY;
  logic [15:0] computerPaddleY;
  logic [7:0]  gameState;
  logic [15:0] ballX;
  logic [15:0] ballY;
  logic [7:0]  playerScore;
  logic [7:0]  computerScore;
  logic        scoreEvent;

  modport master (
    output frameTick, startButton, playerPaddleY, computerPaddleY,
    input  gameState, ballX, ballY, playerScore, computerScore, scoreEvent
  );

  modport slave (
    input  frameTick, startButton, playerPaddleY, computerPaddleY,
    output gameState, ballX, ballY, playerScore, computerScore, scoreEvent
  );
endinterface

// File: rtl/ball_game_engine.sv
// ---------------------------------------------------------------------------
// ball_game_engine
//   Game logic that sits directly upstream of the pixel renderer. Once per
//   video frame it moves the ball, bounces it off the top/bottom walls and
//   both paddles, detects misses, keeps both scores and runs the
//   attract / serve / play / game-over state machine.
//
//   Ports
//     pixelClock  in  sole clock
//     reset       in  synchronous, active-high
//     io_game     slave side of ball_game_engine_if (frameTick, startButton,
//                 paddle positions in; gameState, ball position, scores,
//                 scoreEvent out). All outputs are registered and only
//                 change on the edge that samples frameTick=1, except
//                 scoreEvent which drops back to 0 on the following edge.
// ---------------------------------------------------------------------------
module ball_game_engine #(
  parameter int unsigned SCREEN_W          = 640,
  parameter int unsigned SCREEN_H          = 480,
  parameter int unsigned BALL_W            = 8,
  parameter int unsigned BALL_H            = 8,
  parameter int unsigned PADDLE_W          = 8,
  parameter int unsigned PADDLE_H          = 64,
  parameter int unsigned PLAYER_PADDLE_X   = 16,
  parameter int unsigned COMPUTER_PADDLE_X = 616,
  parameter int unsigned BALL_SPEED        = 4,
  parameter int unsigned WIN_SCORE         = 9,
  parameter int unsigned SERVE_DELAY       = 60
) (
  input  logic                 pixelClock,
  input  logic                 reset,
  ball_game_engine_if.slave    io_game
);

  localparam logic [15:0] L_CX      = 16'((SCREEN_W - BALL_W) / 2);
  localparam logic [15:0] L_CY      = 16'((SCREEN_H - BALL_H) / 2);
  localparam logic [15:0] L_SW      = 16'(SCREEN_W);
  localparam logic [15:0] L_SH      = 16'(SCREEN_H);
  localparam logic [15:0] L_BW      = 16'(BALL_W);
  localparam logic [15:0] L_BH      = 16'(BALL_H);
  localparam logic [15:0] L_PH      = 16'(PADDLE_H);
  localparam logic [15:0] L_SPD     = 16'(BALL_SPEED);
  localparam logic [15:0] L_PFACE   = 16'(PLAYER_PADDLE_X + PADDLE_W);
  localparam logic [15:0] L_CFACE   = 16'(COMPUTER_PADDLE_X);
  localparam logic [15:0] L_SERVE   = 16'(SERVE_DELAY);
  localparam logic [7:0]  L_WIN     = 8'(WIN_SCORE);

  typedef enum logic [1:0] {
    stateAttract  = 2'd0,
    stateServe    = 2'd1,
    statePlay     = 2'd2,
    stateGameOver = 2'd3
  } state_t;

  state_t      r_state,         w_state;
  logic [15:0] r_ballX,         w_ballX;
  logic [15:0] r_ballY,         w_ballY;
  logic        r_dxRight,       w_dxRight;
  logic        r_dyDown,        w_dyDown;
  logic [7:0]  r_playerScore,   w_playerScore;
  logic [7:0]  r_computerScore, w_computerScore;
  logic [15:0] r_serveCount,    w_serveCount;
  logic        r_scoreEvent,    w_scoreEvent;

  // Per-axis results of one play tick, plus hit/miss decisions
  logic [15:0] w_yPlay;
  logic        w_dyPlay;
  logic        w_overlapPlayer;
  logic        w_overlapComputer;
  logic        w_playerHit;
  logic        w_computerHit;
  logic        w_leftMiss;
  logic        w_rightMiss;
  logic [7:0]  w_playerInc;
  logic [7:0]  w_computerInc;

  // State register: everything the game remembers between frames
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      r_state         <= stateAttract;
      r_ballX         <= L_CX;
      r_ballY         <= L_CY;
      r_dxRight       <= 1'b1;
      r_dyDown        <= 1'b1;
      r_playerScore   <= 8'd0;
      r_computerScore <= 8'd0;
      r_serveCount    <= 16'd0;
      r_scoreEvent    <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_ballX         <= w_ballX;
      r_ballY         <= w_ballY;
      r_dxRight       <= w_dxRight;
      r_dyDown        <= w_dyDown;
      r_playerScore   <= w_playerScore;
      r_computerScore <= w_computerScore;
      r_serveCount    <= w_serveCount;
      r_scoreEvent    <= w_scoreEvent;
    end
  end

  // Collision and movement decisions for a play tick. Every compare is
  // ordered so that a subtraction is only formed once the operand is known
  // to be large enough, keeping all arithmetic in 16-bit unsigned.
  always_comb begin
    w_yPlay  = r_ballY;
    w_dyPlay = r_dyDown;
    if (!r_dyDown && (r_ballY <= L_SPD)) begin
      w_yPlay  = 16'd0;
      w_dyPlay = 1'b1;
    end else if (r_dyDown && (r_ballY + L_BH + L_SPD >= L_SH)) begin
      w_yPlay  = L_SH - L_BH;
      w_dyPlay = 1'b0;
    end else if (r_dyDown) begin
      w_yPlay  = r_ballY + L_SPD;
    end else begin
      w_yPlay  = r_ballY - L_SPD;
    end

    // Paddle overlap uses the ball's y before this tick's vertical move
    w_overlapPlayer   = (r_ballY + L_BH > io_game.playerPaddleY) &&
                        (r_ballY < io_game.playerPaddleY + L_PH);
    w_overlapComputer = (r_ballY + L_BH > io_game.computerPaddleY) &&
                        (r_ballY < io_game.computerPaddleY + L_PH);

    w_playerHit   = !r_dxRight && (r_ballX >= L_PFACE) &&
                    (r_ballX - L_SPD <= L_PFACE) && w_overlapPlayer;
    w_computerHit = r_dxRight && (r_ballX + L_BW <= L_CFACE) &&
                    (r_ballX + L_BW + L_SPD >= L_CFACE) && w_overlapComputer;
    w_leftMiss    = !r_dxRight && (r_ballX < L_SPD) && !w_playerHit;
    w_rightMiss   = r_dxRight && (r_ballX + L_BW + L_SPD > L_SW) && !w_computerHit;

    // Scores saturate at the winning value
    w_playerInc   = (r_playerScore   >= L_WIN) ? r_playerScore   : r_playerScore   + 8'd1;
    w_computerInc = (r_computerScore >= L_WIN) ? r_computerScore : r_computerScore + 8'd1;
  end

  // Next-state logic: nothing advances unless frameTick is high, and
  // scoreEvent is forced low on every cycle that does not score.
  always_comb begin
    w_state         = r_state;
    w_ballX         = r_ballX;
    w_ballY         = r_ballY;
    w_dxRight       = r_dxRight;
    w_dyDown        = r_dyDown;
    w_playerScore   = r_playerScore;
    w_computerScore = r_computerScore;
    w_serveCount    = r_serveCount;
    w_scoreEvent    = 1'b0;

    if (io_game.frameTick) begin
      unique case (r_state)
        stateAttract, stateGameOver: begin
          w_ballX = L_CX;
          w_ballY = L_CY;
          if (io_game.startButton) begin
            w_playerScore   = 8'd0;
            w_computerScore = 8'd0;
            w_serveCount    = L_SERVE;
            w_state         = stateServe;
          end
        end

        stateServe: begin
          w_ballX = L_CX;
          w_ballY = L_CY;
          if (r_serveCount == 16'd0) begin
            w_state = statePlay;
          end else begin
            w_serveCount = r_serveCount - 16'd1;
          end
        end

        statePlay: begin
          if (w_leftMiss || w_rightMiss) begin
            // Ball re-serves toward whoever conceded; dy is left as it was
            w_ballX      = L_CX;
            w_ballY      = L_CY;
            w_scoreEvent = 1'b1;
            w_serveCount = L_SERVE;
            w_state      = stateServe;
            if (w_leftMiss) begin
              w_dxRight       = 1'b0;
              w_computerScore = w_computerInc;
              if (w_computerInc == L_WIN) w_state = stateGameOver;
            end else begin
              w_dxRight     = 1'b1;
              w_playerScore = w_playerInc;
              if (w_playerInc == L_WIN) w_state = stateGameOver;
            end
          end else begin
            w_ballY  = w_yPlay;
            w_dyDown = w_dyPlay;
            if (w_playerHit) begin
              w_ballX   = L_PFACE;
              w_dxRight = 1'b1;
            end else if (w_computerHit) begin
              w_ballX   = L_CFACE - L_BW;
              w_dxRight = 1'b0;
            end else if (r_dxRight) begin
              w_ballX   = r_ballX + L_SPD;
            end else begin
              w_ballX   = r_ballX - L_SPD;
            end
          end
        end

        default: begin
          w_state = stateAttract;
        end
      endcase
    end
  end

  assign io_game.gameState     = {6'd0, r_state};
  assign io_game.ballX         = r_ballX;
  assign io_game.ballY         = r_ballY;
  assign io_game.playerScore   = r_playerScore;
  assign io_game.computerScore = r_computerScore;
  assign io_game.scoreEvent    = r_scoreEvent;

endmodule
